round_share_arbiter: RTL and testbench
======================================

Name: round_share_arbiter

Overview:
- Shares one 28-to-24-bit mantissa rounding datapath between two requesting pipelines, for example the add/sub path and the mul path.
- Arbitrates requests round-robin with valid/ready handshakes, rounds the granted mantissa in the accept cycle, and buffers results in a 2-entry output FIFO.
- Each result carries a source ID and a tag so the downstream packer can route it.
- Sits between the normalize stages and the exponent-adjust/pack stage.

Parameters:
- SIZE_MAN, 28, input mantissa width: result bits plus guard, round and two sticky bits.
- SIZE_MAN_RESULT, 24, rounded mantissa width. SIZE_MAN - SIZE_MAN_RESULT must be 4.
- TAG_W, 4, width of the requester tag carried through with each result.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_req0_valid  in  1  requester 0 has a mantissa to round.
- o_req0_ready  out  1  requester 0 is accepted this cycle (this is the grant).
- i_req0_man  in  SIZE_MAN  requester 0 mantissa.
- i_req0_tag  in  TAG_W  requester 0 tag.
- i_req1_valid, o_req1_ready, i_req1_man, i_req1_tag: same as requester 0, for requester 1.
- o_res_valid  out  1  FIFO head holds a valid result.
- i_res_ready  in  1  consumer accepts the head this cycle.
- o_res_man  out  SIZE_MAN_RESULT  rounded mantissa.
- o_res_ovf  out  1  carry out of the rounding increment.
- o_res_src  out  1  source requester of the head entry (0 or 1).
- o_res_tag  out  TAG_W  tag of the head entry.
- o_busy  out  1  FIFO is non-empty or any request valid is high.

Behaviour:
- Clocking and reset: one clock, synchronous active-high reset on i_clk.
- Reset state:
  - FIFO count = 0; read and write pointers = 0.
  - Round-robin pointer rr = 0, so requester 0 has priority first.
  - o_res_valid = 0; o_res_man, o_res_ovf, o_res_src, o_res_tag = 0.
  - o_req0_ready = o_req1_ready = 0 while i_rst is high.
  - Reset mid-operation discards all buffered results; no result is emitted after reset deasserts.
- Rounding function (combinational on the granted mantissa m):
  - g = m[3]; r = m[2]; s = m[1] | m[0].
  - inc = (g & r) | (r & s).
  - {ovf, man} = m[27:4] + inc, computed as a 25-bit sum.
  - ovf = 1 only when m[27:4] = all ones and inc = 1; man then wraps to 0.
- Arbitration:
  - space = (count < 2). No write is allowed on a full FIFO, even if a pop happens in the same cycle.
  - Only one valid high: that requester is granted if space.
  - Both valid: requester rr is granted if space.
  - Any grant to requester k sets rr = ~k on the clock edge.
  - No grant: rr holds.
  - o_reqK_ready = grantK, a combinational function of the valids, rr, count and i_rst.
  - Ready never depends on i_res_ready (no combinational path through it).
- Push: on grant, write {man, ovf, src = k, tag} at the write pointer and increment it (1-bit wrap, 2 entries).
- Pop: when o_res_valid & i_res_ready, increment the read pointer.
- Count update: count += push − pop. Simultaneous push and pop at count = 1 keeps count = 1.
- Latency: a request accepted at edge N appears at the head no earlier than the cycle after edge N. With an empty FIFO it is visible immediately after edge N, i.e. 1-cycle latency.
- Outputs:
  - o_res_* are driven from the head entry.
  - Head fields are held stable while o_res_valid = 1 and i_res_ready = 0.
  - Results leave in grant order.
- Throughput: 1 result per cycle when the consumer is always ready. Sustained throughput is 1 per cycle only while the FIFO does not fill.
- Requesters: must hold man and tag stable while valid is high and not granted. The block does not check this.

Test Plan:
- Rounding values, single request on req0, consumer ready:
  - man 0x000000C -> res_man 0x000001, ovf 0.
  - 0x0000004 -> 0x000000.
  - 0x0000006 -> 0x000001.
  - 0x0000018 -> 0x000001 (upper 24 bits = 1, no increment).
  - 0xFFFFFFC -> res_man 0x000000, ovf 1.
  - Each result is visible 1 cycle after acceptance.
- Fairness: both valid continuously for 6 cycles, consumer ready -> grants alternate 0,1,0,1,0,1; o_res_src follows that sequence and tags match the source.
- Backpressure: i_res_ready = 0, both valid -> exactly 2 grants, then both readies low with count = 2 and head stable. Raise i_res_ready for 1 cycle -> one pop; the next grant occurs the following cycle.
- Simultaneous push/pop: count = 1, request valid, consumer ready -> count stays 1, no bubble, order preserved.
- Reset mid-operation: FIFO holding 2 entries, assert i_rst for 1 cycle -> o_res_valid = 0 and readies low during reset. After release, rr = 0, so with both valid requester 0 is granted first.
- Single requester, no waiting: req1 valid alone while rr = 0 -> req1 granted immediately; rr becomes 0 after the grant.

Source files
------------

// File: rtl/round_share_arbiter.sv
// Two-requester round-robin front end for a shared mantissa rounder.
// Rounded results queue in a 2-entry FIFO and carry source ID and tag to the packer.
module round_share_arbiter #(
    parameter int SIZE_MAN        = 28,
    parameter int SIZE_MAN_RESULT = 24,
    parameter int TAG_W           = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_req0_valid,
    output logic                       o_req0_ready,
    input  logic [SIZE_MAN-1:0]        i_req0_man,
    input  logic [TAG_W-1:0]           i_req0_tag,
    input  logic                       i_req1_valid,
    output logic                       o_req1_ready,
    input  logic [SIZE_MAN-1:0]        i_req1_man,
    input  logic [TAG_W-1:0]           i_req1_tag,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [SIZE_MAN_RESULT-1:0] o_res_man,
    output logic                       o_res_ovf,
    output logic                       o_res_src,
    output logic [TAG_W-1:0]           o_res_tag,
    output logic                       o_busy
);

    localparam int LSB_W = SIZE_MAN - SIZE_MAN_RESULT;
    localparam int DEPTH = 2;

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       rr_q, rr_d;

    logic [SIZE_MAN_RESULT-1:0] man_q [DEPTH];
    logic [SIZE_MAN_RESULT-1:0] man_d [DEPTH];
    logic                       ovf_q [DEPTH];
    logic                       ovf_d [DEPTH];
    logic                       src_q [DEPTH];
    logic                       src_d [DEPTH];
    logic [TAG_W-1:0]           tag_q [DEPTH];
    logic [TAG_W-1:0]           tag_d [DEPTH];

    logic                       space;
    logic                       grant0;
    logic                       grant1;
    logic                       push;
    logic                       pop;
    logic                       res_valid;
    logic [SIZE_MAN-1:0]        sel_man;
    logic [TAG_W-1:0]           sel_tag;
    logic                       rnd_g;
    logic                       rnd_r;
    logic                       rnd_s;
    logic                       rnd_inc;
    logic [SIZE_MAN_RESULT:0]   rnd_sum;

    // Space is judged on the registered count only, so a same-cycle pop never
    // opens a slot and ready has no path from i_res_ready.
    always_comb begin
        space  = (count_q < 2'd2);
        grant0 = !i_rst && space && i_req0_valid && (!i_req1_valid || !rr_q);
        grant1 = !i_rst && space && i_req1_valid && (!i_req0_valid ||  rr_q);
        push   = grant0 || grant1;
    end

    always_comb begin
        sel_man = grant1 ? i_req1_man : i_req0_man;
        sel_tag = grant1 ? i_req1_tag : i_req0_tag;
        rnd_g   = sel_man[LSB_W-1];
        rnd_r   = sel_man[LSB_W-2];
        rnd_s   = |sel_man[LSB_W-3:0];
        rnd_inc = (rnd_g && rnd_r) || (rnd_r && rnd_s);
        rnd_sum = {1'b0, sel_man[SIZE_MAN-1:LSB_W]}
                + {{SIZE_MAN_RESULT{1'b0}}, rnd_inc};
    end

    always_comb begin
        res_valid = !i_rst && (count_q != 2'd0);
        pop       = res_valid && i_res_ready;
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rr_d     = rr_q;

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (grant0) begin
            rr_d = 1'b1;
        end else if (grant1) begin
            rr_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            man_d[i] = man_q[i];
            ovf_d[i] = ovf_q[i];
            src_d[i] = src_q[i];
            tag_d[i] = tag_q[i];
        end
        if (push) begin
            man_d[wr_ptr_q] = rnd_sum[SIZE_MAN_RESULT-1:0];
            ovf_d[wr_ptr_q] = rnd_sum[SIZE_MAN_RESULT];
            src_d[wr_ptr_q] = grant1;
            tag_d[wr_ptr_q] = sel_tag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rr_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_q     <= rr_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; entries are only
    // observable through the valid-gated outputs below, and count reset is
    // what discards them.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            man_q[i] <= man_d[i];
            ovf_q[i] <= ovf_d[i];
            src_q[i] <= src_d[i];
            tag_q[i] <= tag_d[i];
        end
    end

    always_comb begin
        o_req0_ready = grant0;
        o_req1_ready = grant1;
        o_res_valid  = res_valid;
        o_res_man    = res_valid ? man_q[rd_ptr_q] : '0;
        o_res_ovf    = res_valid ? ovf_q[rd_ptr_q] : 1'b0;
        o_res_src    = res_valid ? src_q[rd_ptr_q] : 1'b0;
        o_res_tag    = res_valid ? tag_q[rd_ptr_q] : '0;
        o_busy       = (count_q != 2'd0) || i_req0_valid || i_req1_valid;
    end

endmodule

// File: tb/tb_round_share_arbiter.sv
// Directed self-checking bench for round_share_arbiter: rounding, fairness,
// backpressure, push/pop overlap, mid-run reset and lone-requester grant.
module tb_round_share_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [27:0] req0_man;
    logic [3:0]  req0_tag;
    logic        req1_valid;
    logic        req1_ready;
    logic [27:0] req1_man;
    logic [3:0]  req1_tag;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] res_man;
    logic        res_ovf;
    logic        res_src;
    logic [3:0]  res_tag;
    logic        busy;

    int checks;
    int errors;

    round_share_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .o_req0_ready (req0_ready),
        .i_req0_man   (req0_man),
        .i_req0_tag   (req0_tag),
        .i_req1_valid (req1_valid),
        .o_req1_ready (req1_ready),
        .i_req1_man   (req1_man),
        .i_req1_tag   (req1_tag),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_res_man    (res_man),
        .o_res_ovf    (res_ovf),
        .o_res_src    (res_src),
        .o_res_tag    (res_tag),
        .o_busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_man   = '0;
        req1_man   = '0;
        req0_tag   = '0;
        req1_tag   = '0;
        res_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", res_valid);
        end
        rst = 1'b0;
        idle_inputs();
        step();
        checks++;
        if ({res_man, res_ovf, res_src, res_tag} !== 30'd0) begin
            errors++;
            $display("FAIL reset_fields: got man=%h ovf=%b src=%b tag=%h expected all 0",
                     res_man, res_ovf, res_src, res_tag);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_idle: got %b expected 0", busy);
        end
        req1_valid = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_on_valid: got %b expected 1", busy);
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_rounding();
        logic [27:0] vec_man [6];
        logic [23:0] exp_man [6];
        logic        exp_ovf [6];
        vec_man[0] = 28'h000000C; exp_man[0] = 24'h000001; exp_ovf[0] = 1'b0;
        vec_man[1] = 28'h0000004; exp_man[1] = 24'h000000; exp_ovf[1] = 1'b0;
        vec_man[2] = 28'h0000006; exp_man[2] = 24'h000001; exp_ovf[2] = 1'b0;
        vec_man[3] = 28'h0000018; exp_man[3] = 24'h000001; exp_ovf[3] = 1'b0;
        vec_man[4] = 28'hFFFFFFC; exp_man[4] = 24'h000000; exp_ovf[4] = 1'b1;
        vec_man[5] = 28'h0000008; exp_man[5] = 24'h000000; exp_ovf[5] = 1'b0;
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_valid = 1'b1;
            req0_man   = vec_man[i];
            req0_tag   = 4'(i + 3);
            #1;
            checks++;
            if (req0_ready !== 1'b1) begin
                errors++;
                $display("FAIL round_ready[%0d]: got %b expected 1", i, req0_ready);
            end
            step();
            req0_valid = 1'b0;
            checks++;
            if (res_valid !== 1'b1 || res_man !== exp_man[i] || res_ovf !== exp_ovf[i]
                || res_src !== 1'b0 || res_tag !== 4'(i + 3)) begin
                errors++;
                $display("FAIL round_result[%0d]: got v=%b man=%h ovf=%b src=%b tag=%h expected v=1 man=%h ovf=%b src=0 tag=%h",
                         i, res_valid, res_man, res_ovf, res_src, res_tag,
                         exp_man[i], exp_ovf[i], 4'(i + 3));
            end
            step();
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL round_drain[%0d]: got valid %b expected 0", i, res_valid);
            end
        end
        idle_inputs();
    endtask

    task automatic test_fairness();
        logic exp_src;
        do_reset();
        res_ready  = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_man   = 28'h0000010;
        req1_man   = 28'h0000020;
        req0_tag   = 4'hA;
        req1_tag   = 4'h5;
        for (int i = 0; i < 6; i++) begin
            exp_src = 1'(i % 2);
            #1;
            checks++;
            if (req0_ready !== !exp_src || req1_ready !== exp_src) begin
                errors++;
                $display("FAIL fair_grant[%0d]: got ready0=%b ready1=%b expected grant to %0d",
                         i, req0_ready, req1_ready, exp_src);
            end
            step();
            checks++;
            if (res_valid !== 1'b1 || res_src !== exp_src
                || res_tag !== (exp_src ? 4'h5 : 4'hA)
                || res_man !== (exp_src ? 24'h000002 : 24'h000001)) begin
                errors++;
                $display("FAIL fair_head[%0d]: got v=%b src=%b tag=%h man=%h expected src=%0d",
                         i, res_valid, res_src, res_tag, res_man, exp_src);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL fair_drain: got valid %b expected 0", res_valid);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_tag   = 4'hA;
        req1_tag   = 4'h5;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b1
                || res_src !== 1'b0 || res_tag !== 4'hA) begin
                errors++;
                $display("FAIL bp_full[%0d]: got r0=%b r1=%b v=%b src=%b tag=%h expected r0=0 r1=0 v=1 src=0 tag=a",
                         i, req0_ready, req1_ready, res_valid, res_src, res_tag);
            end
            step();
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_write_on_full: got r0=%b r1=%b expected 00", req0_ready, req1_ready);
        end
        step();
        res_ready = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || res_src !== 1'b1 || res_tag !== 4'h5) begin
            errors++;
            $display("FAIL bp_after_pop: got r0=%b r1=%b src=%b tag=%h expected r0=1 r1=0 src=1 tag=5",
                     req0_ready, req1_ready, res_src, res_tag);
        end
        step();
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_refull: got r0=%b r1=%b expected 00", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        step();
        checks++;
        if (res_valid !== 1'b1 || res_src !== 1'b0 || res_tag !== 4'hA) begin
            errors++;
            $display("FAIL bp_order: got v=%b src=%b tag=%h expected v=1 src=0 tag=a",
                     res_valid, res_src, res_tag);
        end
        step();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got valid %b expected 0", res_valid);
        end
        idle_inputs();
    endtask

    task automatic test_simul_push_pop();
        do_reset();
        req0_valid = 1'b1;
        req0_tag   = 4'h1;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_tag   = 4'h2;
        res_ready  = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || res_src !== 1'b0 || res_tag !== 4'h1) begin
            errors++;
            $display("FAIL pp_pre: got r1=%b src=%b tag=%h expected r1=1 src=0 tag=1",
                     req1_ready, res_src, res_tag);
        end
        step();
        req1_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_src !== 1'b1 || res_tag !== 4'h2) begin
            errors++;
            $display("FAIL pp_no_bubble: got v=%b src=%b tag=%h expected v=1 src=1 tag=2",
                     res_valid, res_src, res_tag);
        end
        step();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL pp_count_one: got valid %b expected 0", res_valid);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_valid = 1'b1;
        req0_tag   = 4'hA;
        req1_tag   = 4'h5;
        step();
        step();
        rst        = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_during: got r0=%b r1=%b v=%b expected 000",
                     req0_ready, req1_ready, res_valid);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_after: got v=%b r0=%b r1=%b expected v=0 r0=1 r1=0",
                     res_valid, req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        checks++;
        if (res_valid !== 1'b1 || res_src !== 1'b0 || res_tag !== 4'hA) begin
            errors++;
            $display("FAIL mid_rst_first: got v=%b src=%b tag=%h expected v=1 src=0 tag=a",
                     res_valid, res_src, res_tag);
        end
        step();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_drain: got valid %b expected 0", res_valid);
        end
        idle_inputs();
    endtask

    task automatic test_single_req1();
        do_reset();
        res_ready  = 1'b1;
        req1_valid = 1'b1;
        req1_tag   = 4'h7;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: got r0=%b r1=%b expected r0=0 r1=1", req0_ready, req1_ready);
        end
        step();
        checks++;
        if (res_valid !== 1'b1 || res_src !== 1'b1 || res_tag !== 4'h7) begin
            errors++;
            $display("FAIL single_head: got v=%b src=%b tag=%h expected v=1 src=1 tag=7",
                     res_valid, res_src, res_tag);
        end
        req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_rr_back: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got valid %b expected 0", res_valid);
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_rounding();
        test_fairness();
        test_backpressure();
        test_simul_push_pop();
        test_reset_mid();
        test_single_req1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
